fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction memory and feeds decode. It drives the IMEM address/read lines, tracks the memory's one-cycle registered read latency, and presents each returned word with its PC and a valid flag. It also handles decode back-pressure (stall) and control-flow redirects. The IMEM holds its registered address when its read strobe is low, so a held word stays stable without a skid buffer.

## Interface
- ISIZE, 16, address / PC width; word addressing, one instruction per address
- DSIZE, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- imem_addr  out  ISIZE  IMEM address; combinational
- imem_read  out  1  IMEM read strobe; combinational
- imem_data  in  DSIZE  IMEM read data; the word at the address sampled on the previous read edge
- stall  in  1  decode not ready; freezes fetch
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  ISIZE  redirect target
- if_valid  out  1  if_instr/if_pc hold a live instruction
- if_instr  out  DSIZE  fetched instruction (imem_data passed through)
- if_pc  out  ISIZE  address of if_instr
- fetch_count  out  16  number of accepted instructions, saturating

## Operation
- State: pc (next fetch address), req_valid, req_pc (address of the outstanding response), fetch_count.
- Two states via req_valid: IDLE (0, after reset) and ACTIVE (1). IDLE->ACTIVE on the first issue. Only rst returns to IDLE.
- Outputs: if_valid = req_valid & ~redirect_valid; if_instr = imem_data; if_pc = req_pc.
- Accept = if_valid & ~stall. The consumer latches on accept.
- Next-state priority, evaluated each posedge:
  1. rst: pc<=RESET_PC, req_valid<=0, req_pc<=RESET_PC, fetch_count<=0. imem_read=0, imem_addr=RESET_PC.
  2. redirect_valid: imem_addr=redirect_pc, imem_read=1; pc<=redirect_pc+1, req_pc<=redirect_pc, req_valid<=1. The currently presented instruction is dropped (if_valid masked to 0).
  3. stall: imem_read=0, imem_addr=pc; all state holds. The IMEM keeps its address, so imem_data stays stable.
  4. otherwise: imem_addr=pc, imem_read=1; pc<=pc+1, req_pc<=pc, req_valid<=1.
- Stall freezes fetch regardless of req_valid.
- redirect_valid overrides stall.
- fetch_count increments by 1 on accept and saturates at 0xFFFF.
- pc+1 and redirect_pc+1 wrap modulo 2^ISIZE (0xFFFF+1 = 0x0000).
- No memwrite path: the IMEM write strobe is tied low outside this block.

## Timing
- Reset values: if_valid=0, if_pc=RESET_PC, fetch_count=0, imem_read=0, imem_addr=RESET_PC. if_instr is whatever the IMEM outputs.
- The IMEM loads its contents while rst=1. Fetch issues no reads during reset.
- Cycle 0 is the first cycle with rst=0: the read of RESET_PC is issued and if_valid=0.
- Cycle 1: if_valid=1, if_pc=RESET_PC. Latency is 1 cycle from issue to presentation.
- Steady state without stall: one instruction per cycle, no bubbles.
- Stall released in cycle N: the presented instruction is accepted in N, and the next instruction is presented in N+1. No bubble.
- Redirect in cycle N: if_valid=0 in N; target presented in N+1. Penalty is 1 cycle.
- rst asserted mid-stream (including during stall or redirect): the reset values apply on the next cycle, and the in-flight instruction is discarded.

## Test plan
- Reset release, RESET_PC=0, IMEM word k = 0x1000+k, stall=0 -> cycle 0 if_valid=0; cycles 1..4 present if_pc 0,1,2,3 with if_instr 0x1000..0x1003; after 10 accepts fetch_count=10.
- stall=1 for 3 cycles while if_pc=2 is presented -> imem_read=0 and if_instr holds 0x1002 all 3 cycles with fetch_count unchanged; the release cycle accepts pc 2, and the next cycle presents pc 3 / 0x1003.
- redirect_valid with redirect_pc=0x0040 while if_pc=5 is presented -> if_valid=0 that cycle and pc 5 is not counted; next cycle if_pc=0x0040 with 0x1040, then 0x0041.
- redirect_valid and stall asserted together, redirect_pc=0x0010 -> imem_read=1 and imem_addr=0x0010; next cycle if_pc=0x0010 is presented (held, since stall is still 1).
- redirect_pc=0xFFFF with stall=0 -> imem_addr sequence 0xFFFF then 0x0000; if_pc 0xFFFF then 0x0000.
- rst asserted while if_pc=7 and stall=1 -> next cycle if_valid=0, fetch_count=0, imem_read=0; after release, fetch restarts at RESET_PC with the cycle-0/cycle-1 behaviour above.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a one-cycle-latency IMEM and presents each returned
// word with its PC. Handles decode stall and control-flow redirects.
module fetch_unit #(
    parameter int               ISIZE    = 16,
    parameter int               DSIZE    = 32,
    parameter logic [ISIZE-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ISIZE-1:0] imem_addr,
    output logic             imem_read,
    input  logic [DSIZE-1:0] imem_data,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic             if_valid,
    output logic [DSIZE-1:0] if_instr,
    output logic [ISIZE-1:0] if_pc,
    output logic [15:0]      fetch_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ISIZE-1:0] pc_q, pc_d;
    logic [ISIZE-1:0] req_pc_q, req_pc_d;
    logic [15:0]      count_q, count_d;
    logic             accept;

    // A redirect kills whatever is being presented this cycle.
    assign if_valid    = (state_q == ACTIVE) && !redirect_valid;
    assign if_instr    = imem_data;
    assign if_pc       = req_pc_q;
    assign fetch_count = count_q;
    assign accept      = if_valid && !stall;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        count_d   = count_q;
        imem_addr = pc_q;
        imem_read = 1'b0;

        if (rst) begin
            imem_addr = RESET_PC;
        end else if (redirect_valid) begin
            imem_addr = redirect_pc;
            imem_read = 1'b1;
            pc_d      = redirect_pc + ISIZE'(1);
            req_pc_d  = redirect_pc;
            state_d   = ACTIVE;
        end else if (!stall) begin
            imem_read = 1'b1;
            pc_d      = pc_q + ISIZE'(1);
            req_pc_d  = pc_q;
            state_d   = ACTIVE;
        end
        // On stall the IMEM keeps its registered address, so imem_data holds itself.

        if (accept && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus with a behavioural registered-read
// IMEM (word k = 0x1000 + k); a monitor pops expected PCs on every accept.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] fetch_count;

    int          total  = 0;
    int          passed = 0;
    logic [15:0] exp_q[$];

    fetch_unit #(.ISIZE(16), .DSIZE(32), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_read      (imem_read),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // IMEM model: registered read, holds its output when the strobe is low.
    always @(posedge clk) begin
        if (imem_read) imem_data <= 32'h1000 + {16'h0000, imem_addr};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Drive one cycle's inputs just after the edge, then wait for the sampling edge.
    task automatic cyc(input logic r, input logic s, input logic rv, input logic [15:0] rp);
        @(posedge clk);
        #1;
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(negedge clk);
    endtask

    // Monitor: every accepted instruction must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && if_valid && !stall) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_accept: got pc %h, required no accept", if_pc);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                $display("accept pc=%h instr=%h count=%0d", if_pc, if_instr, fetch_count);
                chk("accept_pc", {16'h0, if_pc}, {16'h0, e});
                chk("accept_instr", if_instr, 32'h1000 + {16'h0, e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;

        // ---------------- reset, streaming and stall ----------------
        cyc(1, 0, 0, 16'h0); cyc(1, 0, 0, 16'h0);
        chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_if_pc", {16'h0, if_pc}, 32'h0);
        chk("rst_count", {16'h0, fetch_count}, 32'h0);
        chk("rst_imem_read", {31'h0, imem_read}, 32'h0);
        chk("rst_imem_addr", {16'h0, imem_addr}, 32'h0);
        for (int i = 0; i < 10; i++) exp_q.push_back(16'(i));

        cyc(0, 0, 0, 16'h0);  // cycle 0
        chk("c0_if_valid", {31'h0, if_valid}, 32'h0);
        chk("c0_imem_read", {31'h0, imem_read}, 32'h1);
        chk("c0_imem_addr", {16'h0, imem_addr}, 32'h0);
        cyc(0, 0, 0, 16'h0);  // cycle 1
        chk("c1_if_valid", {31'h0, if_valid}, 32'h1);
        chk("c1_if_pc", {16'h0, if_pc}, 32'h0);
        cyc(0, 0, 0, 16'h0);  // cycle 2
        chk("c2_if_pc", {16'h0, if_pc}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 16'h0);
            chk("stall_imem_read", {31'h0, imem_read}, 32'h0);
            chk("stall_if_instr", if_instr, 32'h1002);
            chk("stall_if_pc", {16'h0, if_pc}, 32'h2);
            chk("stall_count", {16'h0, fetch_count}, 32'h2);
        end
        cyc(0, 0, 0, 16'h0);  // release: pc 2 accepted
        chk("release_pc", {16'h0, if_pc}, 32'h2);
        cyc(0, 0, 0, 16'h0);
        chk("post_release_pc", {16'h0, if_pc}, 32'h3);
        chk("post_release_instr", if_instr, 32'h1003);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 16'h0);
        cyc(0, 1, 0, 16'h0);
        chk("count_10", {16'h0, fetch_count}, 32'd10);
        chk("count_10_pc", {16'h0, if_pc}, 32'd10);

        // ---------------- redirects ----------------
        cyc(1, 0, 0, 16'h0); cyc(1, 0, 0, 16'h0);
        chk("rst2_count", {16'h0, fetch_count}, 32'h0);
        for (int i = 0; i < 5; i++) exp_q.push_back(16'(i));
        exp_q.push_back(16'h0040); exp_q.push_back(16'h0041);
        cyc(0, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 16'h0);
        cyc(0, 0, 1, 16'h0040);  // pc 5 presented, dropped
        chk("redir_pc5_shown", {16'h0, if_pc}, 32'h5);
        chk("redir_if_valid", {31'h0, if_valid}, 32'h0);
        chk("redir_imem_addr", {16'h0, imem_addr}, 32'h0040);
        chk("redir_imem_read", {31'h0, imem_read}, 32'h1);
        cyc(0, 0, 0, 16'h0);
        chk("redir_target_pc", {16'h0, if_pc}, 32'h0040);
        cyc(0, 0, 0, 16'h0);
        chk("redir_target_next", {16'h0, if_pc}, 32'h0041);
        cyc(0, 1, 1, 16'h0010);  // redirect overrides stall
        chk("rs_if_valid", {31'h0, if_valid}, 32'h0);
        chk("rs_imem_read", {31'h0, imem_read}, 32'h1);
        chk("rs_imem_addr", {16'h0, imem_addr}, 32'h0010);
        chk("rs_count_skip5", {16'h0, fetch_count}, 32'd7);
        cyc(0, 1, 0, 16'h0);
        chk("rs_held_valid", {31'h0, if_valid}, 32'h1);
        chk("rs_held_pc", {16'h0, if_pc}, 32'h0010);
        chk("rs_held_instr", if_instr, 32'h1010);
        chk("rs_held_read", {31'h0, imem_read}, 32'h0);
        exp_q.push_back(16'h0010);
        cyc(0, 0, 0, 16'h0);
        exp_q.push_back(16'hFFFF);
        cyc(0, 0, 1, 16'hFFFF);
        chk("wrap_redir_valid", {31'h0, if_valid}, 32'h0);
        chk("wrap_addr0", {16'h0, imem_addr}, 32'hFFFF);
        cyc(0, 0, 0, 16'h0);
        chk("wrap_addr1", {16'h0, imem_addr}, 32'h0000);
        chk("wrap_pc0", {16'h0, if_pc}, 32'hFFFF);
        cyc(0, 1, 0, 16'h0);
        chk("wrap_pc1", {16'h0, if_pc}, 32'h0000);
        chk("wrap_instr1", if_instr, 32'h1000);
        chk("wrap_valid1", {31'h0, if_valid}, 32'h1);

        // ---------------- reset mid-stream under stall ----------------
        cyc(1, 0, 0, 16'h0); cyc(1, 0, 0, 16'h0);
        for (int i = 0; i < 7; i++) exp_q.push_back(16'(i));
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 16'h0);
        cyc(0, 1, 0, 16'h0);
        chk("pre_rst_pc", {16'h0, if_pc}, 32'h7);
        chk("pre_rst_count", {16'h0, fetch_count}, 32'h7);
        cyc(1, 1, 0, 16'h0);
        cyc(1, 1, 0, 16'h0);
        chk("mid_rst_valid", {31'h0, if_valid}, 32'h0);
        chk("mid_rst_count", {16'h0, fetch_count}, 32'h0);
        chk("mid_rst_read", {31'h0, imem_read}, 32'h0);
        chk("mid_rst_pc", {16'h0, if_pc}, 32'h0);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
        cyc(0, 0, 0, 16'h0);
        chk("restart_c0_valid", {31'h0, if_valid}, 32'h0);
        chk("restart_c0_read", {31'h0, imem_read}, 32'h1);
        chk("restart_c0_addr", {16'h0, imem_addr}, 32'h0);
        cyc(0, 0, 0, 16'h0);
        chk("restart_c1_pc", {16'h0, if_pc}, 32'h0);
        cyc(0, 0, 0, 16'h0);
        cyc(0, 1, 0, 16'h0);
        chk("restart_count", {16'h0, fetch_count}, 32'h2);
        chk("queue_empty", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
